inst_fetch: RTL

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 26 ++
 rtl/if_hold_buf.sv | 28 ++
 rtl/inst_fetch.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds state encodings, exception bit positions and the reset vector.
package inst_fetch_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam int unsigned EXC_IF_ADEL = 0;

    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        HOLD = 3'd3,
        KILL = 3'd4,
        HALT = 3'd5
    } if_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_word_t;

endpackage

// File: rtl/if_hold_buf.sv
// Holding register for a fetched word that arrived while the
// downstream register was stalled; keeps pc and instruction together.
module if_hold_buf
    import inst_fetch_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     load,
    input  logic     clear,
    input  if_word_t din,
    output if_word_t dout
);

    if_word_t q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end
    end

    assign dout = q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: one outstanding request, stall hold buffer,
// pending branch capture, flush redirect and misaligned-fetch trap.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_gnt,
    input  logic        inst_rvalid,
    input  logic [31:0] inst_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        valid_pc_o,
    output logic        al_hav_o,
    output logic [31:0] except_o
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        bp_valid_q, bp_valid_d;
    logic [31:0] bp_pc_q, bp_pc_d;

    logic        hold_load;
    logic        hold_clear;
    if_word_t    hold_din;
    if_word_t    hold_dout;

    logic        misalign;
    logic        advance;
    logic [31:0] next_pc;

    assign inst_addr = pc_q;
    assign misalign  = (pc_q[1:0] != 2'b00);
    assign hold_din  = '{pc: pc_q, inst: inst_rdata};

    // A held branch is older than one arriving now, so it wins.
    assign next_pc = bp_valid_q  ? bp_pc_q   :
                     branch_flag ? branch_pc :
                     pc_q + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            bp_valid_q <= FALSE;
            bp_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            bp_valid_q <= bp_valid_d;
            bp_pc_q    <= bp_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        bp_valid_d = bp_valid_q;
        bp_pc_d    = bp_pc_q;
        hold_load  = FALSE;
        hold_clear = FALSE;
        advance    = FALSE;
        inst_req   = FALSE;
        valid_pc_o = FALSE;
        al_hav_o   = FALSE;
        if_pc      = '0;
        if_inst    = '0;
        except_o   = '0;

        unique case (state_q)
            IDLE: begin
                state_d = ADDR;
            end
            ADDR: begin
                if (misalign) begin
                    valid_pc_o            = TRUE;
                    if_pc                 = pc_q;
                    except_o[EXC_IF_ADEL] = TRUE;
                    if (!stall) begin
                        state_d = HALT;
                    end
                end else begin
                    inst_req = TRUE;
                    if (inst_gnt) begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (inst_rvalid) begin
                    if (!stall) begin
                        valid_pc_o = TRUE;
                        if_pc      = pc_q;
                        if_inst    = inst_rdata;
                        advance    = TRUE;
                        state_d    = ADDR;
                    end else begin
                        hold_load = TRUE;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                al_hav_o = TRUE;
                if_pc    = hold_dout.pc;
                if_inst  = hold_dout.inst;
                if (!stall) begin
                    advance = TRUE;
                    state_d = ADDR;
                end
            end
            KILL: begin
                if (inst_rvalid) begin
                    state_d = ADDR;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (advance) begin
            pc_d       = next_pc;
            bp_valid_d = FALSE;
        end else if (branch_flag) begin
            bp_valid_d = TRUE;
            bp_pc_d    = branch_pc;
        end

        // Flush overrides everything above; an in-flight response is killed.
        if (flush) begin
            pc_d       = flush_pc;
            bp_valid_d = FALSE;
            hold_load  = FALSE;
            hold_clear = TRUE;
            valid_pc_o = FALSE;
            al_hav_o   = FALSE;
            if_pc      = '0;
            if_inst    = '0;
            except_o   = '0;
            unique case (state_q)
                ADDR:    state_d = (inst_req && inst_gnt) ? KILL : ADDR;
                DATA:    state_d = inst_rvalid ? ADDR : KILL;
                KILL:    state_d = inst_rvalid ? ADDR : KILL;
                default: state_d = ADDR;
            endcase
        end
    end

    if_hold_buf u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (hold_load),
        .clear (hold_clear),
        .din   (hold_din),
        .dout  (hold_dout)
    );

endmodule
